// File: rtl/alu_muldiv_if.sv
// Request/result bundle for the iterative multiply/divide unit.
// Carries o_div_zero only when ALU_MULDIV_DIVZERO_EN is defined.
interface alu_muldiv_if #(
  parameter int NB_BITS = 32,
  parameter int NB_OPE  = 5
);
  logic               i_start;
  logic [NB_OPE-1:0]  i_ope_sel;
  logic [NB_BITS-1:0] i_data_a;
  logic [NB_BITS-1:0] i_data_b;
  logic [NB_BITS-1:0] o_hi;
  logic [NB_BITS-1:0] o_lo;
  logic               o_busy;
  logic               o_done;
`ifdef ALU_MULDIV_DIVZERO_EN
  logic               o_div_zero;

  modport master (
    output i_start, i_ope_sel, i_data_a, i_data_b,
    input  o_hi, o_lo, o_busy, o_done, o_div_zero
  );
  modport slave (
    input  i_start, i_ope_sel, i_data_a, i_data_b,
    output o_hi, o_lo, o_busy, o_done, o_div_zero
  );
`else
  modport master (
    output i_start, i_ope_sel, i_data_a, i_data_b,
    input  o_hi, o_lo, o_busy, o_done
  );
  modport slave (
    input  i_start, i_ope_sel, i_data_a, i_data_b,
    output o_hi, o_lo, o_busy, o_done
  );
`endif
endinterface

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO.
// ALU_MULDIV_DIVZERO_EN: divide by zero finishes early with o_div_zero.
module alu_muldiv #(
  parameter int NB_BITS = 32,
  parameter int NB_OPE  = 5
) (
  input logic         i_clock,
  input logic         i_reset,
  alu_muldiv_if.slave bus
);
  localparam int N = NB_BITS;
  localparam logic [NB_OPE-1:0] OP_MULT  = NB_OPE'(16);
  localparam logic [NB_OPE-1:0] OP_MULTU = NB_OPE'(17);
  localparam logic [NB_OPE-1:0] OP_DIV   = NB_OPE'(18);
  localparam logic [NB_OPE-1:0] OP_DIVU  = NB_OPE'(19);
  localparam logic [NB_OPE-1:0] OP_MTHI  = NB_OPE'(20);
  localparam logic [NB_OPE-1:0] OP_MTLO  = NB_OPE'(21);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t         state;
  logic [N-1:0]   hi, lo, opd, cnt;
  logic [2*N-1:0] acc;
  logic           busy, done, is_div, neg_q, neg_r;
`ifdef ALU_MULDIV_DIVZERO_EN
  logic           dz, div_zero;
`endif

  logic           op_mul, op_div, op_sgn;
  logic           op_mthi, op_mtlo, sgn_a, sgn_b, rem_ge;
  logic [N-1:0]   a_mag, b_mag, rem_sub;
  logic [N-1:0]   q_fix, r_fix, hi_fix, lo_fix;
  logic [N:0]     rem_sh, mul_sum;
  logic [2*N-1:0] mul_next, div_next, prod_fix;

  always_comb begin
    op_mul  = bus.i_ope_sel == OP_MULT ||
              bus.i_ope_sel == OP_MULTU;
    op_div  = bus.i_ope_sel == OP_DIV ||
              bus.i_ope_sel == OP_DIVU;
    op_sgn  = bus.i_ope_sel == OP_MULT ||
              bus.i_ope_sel == OP_DIV;
    op_mthi = bus.i_ope_sel == OP_MTHI;
    op_mtlo = bus.i_ope_sel == OP_MTLO;
    sgn_a   = op_sgn & bus.i_data_a[N-1];
    sgn_b   = op_sgn & bus.i_data_b[N-1];
    a_mag   = sgn_a ? -bus.i_data_a : bus.i_data_a;
    b_mag   = sgn_b ? -bus.i_data_b : bus.i_data_b;
    // acc = {partial product, multiplier} or {remainder, dividend/quotient}
    mul_sum  = {1'b0, acc[2*N-1:N]} +
               (acc[0] ? {1'b0, opd} : {(N+1){1'b0}});
    mul_next = {mul_sum, acc[N-1:1]};
    rem_sh   = acc[2*N-1:N-1];
    rem_ge   = rem_sh >= {1'b0, opd};
    rem_sub  = rem_sh[N-1:0] - opd;
    div_next = rem_ge ?
               {rem_sub, acc[N-2:0], 1'b1} :
               {rem_sh[N-1:0], acc[N-2:0], 1'b0};
    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[N-1:0] : acc[N-1:0];
    r_fix    = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];
    hi_fix   = is_div ? r_fix : prod_fix[2*N-1:N];
    lo_fix   = is_div ? q_fix : prod_fix[N-1:0];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state  <= S_IDLE;
      hi     <= '0;
      lo     <= '0;
      opd    <= '0;
      cnt    <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`ifdef ALU_MULDIV_DIVZERO_EN
      dz       <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ALU_MULDIV_DIVZERO_EN
      div_zero <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            unique case (1'b1)
              op_mul, op_div: begin
                acc    <= {{N{1'b0}},
                           op_div ? a_mag : b_mag};
                opd    <= op_div ? b_mag : a_mag;
                is_div <= op_div;
                neg_q  <= sgn_a ^ sgn_b;
                neg_r  <= sgn_a;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= S_RUN;
`ifdef ALU_MULDIV_DIVZERO_EN
                dz <= op_div && bus.i_data_b == '0;
                if (op_div && bus.i_data_b == '0)
                  state <= S_FIX;
`endif
              end
              op_mthi: hi <= bus.i_data_a;
              op_mtlo: lo <= bus.i_data_a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + N'(1);
          if (cnt == N'(N-1))
            state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef ALU_MULDIV_DIVZERO_EN
          div_zero <= dz;
          if (!dz) begin
            hi <= hi_fix;
            lo <= lo_fix;
          end
`else
          hi <= hi_fix;
          lo <= lo_fix;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_hi   = hi;
  assign bus.o_lo   = lo;
  assign bus.o_busy = busy;
  assign bus.o_done = done;
`ifdef ALU_MULDIV_DIVZERO_EN
  assign bus.o_div_zero = div_zero;
`endif
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed + random bench for alu_muldiv against an arithmetic model.
// Honours ALU_MULDIV_DIVZERO_EN when defined.
module tb_alu_muldiv;
  localparam logic [4:0] MULT  = 5'h10;
  localparam logic [4:0] MULTU = 5'h11;
  localparam logic [4:0] DIV   = 5'h12;
  localparam logic [4:0] DIVU  = 5'h13;
  localparam logic [4:0] MTHI  = 5'h14;
  localparam logic [4:0] MTLO  = 5'h15;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  alu_muldiv_if bus ();

  alu_muldiv dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_op(
    input logic [4:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa, sb, q, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (op)
      MULTU: r = {32'h0, a} * {32'h0, b};
      MULT:  r = 64'(sa * sb);
      DIVU:  r = (b == 0) ? {a, 32'hFFFFFFFF} :
                 {a % b, a / b};
      DIV: begin
        q  = sa / sb;
        rm = sa % sb;
        r  = {rm[31:0], q[31:0]};
      end
      default: r = {m_hi, m_lo};
    endcase
    return r;
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // call at a negedge; returns 1ns after the accepting edge
  task automatic issue(
    input logic [4:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    bus.i_start   = 1'b1;
    bus.i_ope_sel = op;
    bus.i_data_a  = a;
    bus.i_data_b  = b;
    @(posedge clk);
    #1;
    bus.i_start  = 1'b0;
    bus.i_data_a = $urandom;
    bus.i_data_b = $urandom;
  endtask

  // runs a multi-cycle op; returns at the negedge of the done cycle
  task automatic mdop(
    input string tag,
    input logic [4:0] op,
    input logic [31:0] a,
    input logic [31:0] b,
    input int inj
  );
    logic [63:0] e;
    int lat, nbusy;
    logic dz;
    dz = 1'b0;
`ifdef ALU_MULDIV_DIVZERO_EN
    dz = (op == DIV || op == DIVU) && b == 0;
`endif
    e = ref_op(op, a, b);
    if (!dz) begin
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
    issue(op, a, b);
    lat = 0;
    nbusy = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.o_done) break;
      if (bus.o_busy) nbusy++;
      if (lat == inj) begin
        bus.i_start   = 1'b1;
        bus.i_ope_sel = MTHI;
        bus.i_data_a  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
      end
    end
    chk({tag, "_lat"}, lat, dz ? 2 : 34);
    chk({tag, "_busycyc"}, nbusy, dz ? 1 : 33);
    chk({tag, "_done"}, bus.o_done, 1);
    chk({tag, "_busy0"}, bus.o_busy, 0);
    chk({tag, "_hi"}, bus.o_hi, m_hi);
    chk({tag, "_lo"}, bus.o_lo, m_lo);
`ifdef ALU_MULDIV_DIVZERO_EN
    chk({tag, "_dz"}, bus.o_div_zero, dz);
`endif
  endtask

  // single-cycle or no-op request, checked one cycle later
  task automatic simple(
    input string tag,
    input logic [4:0] op,
    input logic [31:0] a
  );
    if (op == MTHI) m_hi = a;
    if (op == MTLO) m_lo = a;
    issue(op, a, $urandom);
    @(negedge clk);
    chk({tag, "_hi"}, bus.o_hi, m_hi);
    chk({tag, "_lo"}, bus.o_lo, m_lo);
    chk({tag, "_done"}, bus.o_done, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] op;
    logic [31:0] a, b;
    rst           = 1'b1;
    bus.i_start   = 1'b0;
    bus.i_ope_sel = '0;
    bus.i_data_a  = '0;
    bus.i_data_b  = '0;
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", bus.o_hi, 0);
    chk("rst_lo", bus.o_lo, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    rst = 1'b0;
    @(negedge clk);

    mdop("t1_multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("t1_hi_k", bus.o_hi, 32'hFFFFFFFE);
    chk("t1_lo_k", bus.o_lo, 32'h00000001);

    mdop("t2_mult", MULT, 32'hFFFFFFFD, 32'd5, 0);
    chk("t2_mult_lo_k", bus.o_lo, 32'hFFFFFFF1);
    mdop("t2_div", DIV, 32'hFFFFFFF9, 32'd2, 0);
    chk("t2_div_lo_k", bus.o_lo, 32'hFFFFFFFD);
    mdop("t2_divu", DIVU, 32'd100, 32'd7, 0);
    chk("t2_divu_lo_k", bus.o_lo, 32'h0000000E);
    mdop("t2_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("t2_ovf_lo_k", bus.o_lo, 32'h80000000);
    chk("t2_ovf_hi_k", bus.o_hi, 32'h0);

    mdop("t3_busy_mt", MULTU, 32'd3, 32'd4, 4);
    chk("t3_lo_k", bus.o_lo, 32'h0000000C);
    simple("t3_mthi", MTHI, 32'hDEADBEEF);
    simple("t3_mtlo", MTLO, 32'h12345678);
    simple("undef_16", 5'h16, 32'hA5A5A5A5);
    simple("undef_00", 5'h00, 32'h5A5A5A5A);

    simple("t4_mthi", MTHI, 32'h00001234);
    issue(DIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    chk("t4_rst_busy", bus.o_busy, 0);
    chk("t4_rst_done", bus.o_done, 0);
    chk("t4_rst_hi", bus.o_hi, 0);
    chk("t4_rst_lo", bus.o_lo, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mdop("t4_multu", MULTU, 32'd2, 32'd2, 0);

    mdop("t5_mul", MULTU, 32'd6, 32'd7, 0);
    chk("t5_lo1_k", bus.o_lo, 32'h0000002A);
    mdop("t5_div", DIVU, 32'd42, 32'd5, 0);
    chk("t5_lo2_k", bus.o_lo, 32'h00000008);
    @(negedge clk);
    chk("t5_done_w", bus.o_done, 0);

    mdop("t6_dz", DIVU, 32'h0000002A, 32'h0, 0);

    for (int i = 0; i < 24; i++) begin
      op = MULT + 5'($urandom_range(0, 3));
      a = pick();
      b = pick();
`ifndef ALU_MULDIV_DIVZERO_EN
      if (op == DIV && b == 0) b = 32'd3;
`endif
      mdop("rnd", op, a, b, 0);
      if (i % 6 == 5)
        simple("rnd_mt", ($urandom_range(0, 1) != 0) ? MTHI : MTLO,
               $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
